// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: a serial frame of four W-bit slots, marked by sync on the
// first bit, is split into per-channel registered words with completion pulses.
module tdm_demux4 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    input  logic         sync,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2,
    output logic [W-1:0] ch3,
    output logic [3:0]   ch_valid,
    output logic         frame_done,
    output logic         locked,
    output logic         sync_err
);

    localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
    localparam int unsigned SW   = W - 1;
    localparam logic [CntW-1:0] LastBit = CntW'(W - 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_q, bit_d;
    logic [1:0]      slot_q, slot_d;
    // Only the W-1 bits before the completing bit need storing; the last bit comes from din.
    logic [SW-1:0]   shift_q, shift_d;
    logic [W-1:0]    ch_q [4];
    logic [W-1:0]    ch_d [4];
    logic [3:0]      ch_valid_q, ch_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q, sync_err_d;

    logic [W-1:0] word;
    logic         at_start;

    assign word     = {shift_q, din};
    assign at_start = (bit_q == '0) && (slot_q == 2'd0);

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        slot_d       = slot_q;
        shift_d      = shift_q;
        ch_d         = ch_q;
        ch_valid_d   = 4'b0000;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (en) begin
            unique case (state_q)
                StHunt: begin
                    if (sync) begin
                        state_d = StLocked;
                        shift_d = SW'(din);
                        bit_d   = CntW'(1);
                        slot_d  = 2'd0;
                    end
                end
                StLocked: begin
                    if (at_start && !sync) begin
                        sync_err_d = 1'b1;
                        state_d    = StHunt;
                        bit_d      = '0;
                        slot_d     = 2'd0;
                        shift_d    = '0;
                    end else if (!at_start && sync) begin
                        // Resynchronise: drop the partial word and restart the frame here.
                        sync_err_d = 1'b1;
                        shift_d    = SW'(din);
                        bit_d      = CntW'(1);
                        slot_d     = 2'd0;
                    end else begin
                        shift_d = word[SW-1:0];
                        if (bit_q == LastBit) begin
                            bit_d        = '0;
                            slot_d       = slot_q + 2'd1;
                            ch_d[slot_q] = word;
                            ch_valid_d   = 4'b0001 << slot_q;
                            frame_done_d = (slot_q == 2'd3);
                        end else begin
                            bit_d = bit_q + CntW'(1);
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHunt;
            bit_q        <= '0;
            slot_q       <= 2'd0;
            shift_q      <= '0;
            ch_q         <= '{default: '0};
            ch_valid_q   <= 4'b0000;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            slot_q       <= slot_d;
            shift_q      <= shift_d;
            ch_q         <= ch_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (W=8): expected words are queued as frames are driven and matched
// against every ch_valid pulse, including its cycle of arrival.
module tb_tdm_demux4;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         din;
    logic         sync;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         locked;
    logic         sync_err;

    tdm_demux4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .sync      (sync),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .ch_valid  (ch_valid),
        .frame_done(frame_done),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    typedef struct {
        int          slot;
        logic [7:0]  word;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    logic        en_s     = 1'b0;
    logic        rst_s    = 1'b0;
    logic        serr_ok  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ch_sel(input int s);
        case (s)
            0:       return ch0;
            1:       return ch1;
            2:       return ch2;
            default: return ch3;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        en_s  <= en;
        rst_s <= rst;
    end

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check_eq($sformatf("missing_pulse_slot%0d", e.slot), 32'(ch_valid), 32'(1) << e.slot);
        end
        if ((!en_s || rst_s) && (ch_valid != 4'b0 || frame_done || sync_err))
            check_eq("pulse_without_en", {30'b0, frame_done, sync_err} | 32'(ch_valid), 32'd0);
        else if (ch_valid != 4'b0 || frame_done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pulse", {27'b0, frame_done, ch_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("ch_valid", 32'(ch_valid), 32'(1) << e.slot);
                check_eq("frame_done", 32'(frame_done), 32'(e.slot == 3));
                check_eq($sformatf("word_ch%0d", e.slot), 32'(ch_sel(e.slot)), 32'(e.word));
                check_eq("latency", cyc, e.cyc);
            end
        end
        if (sync_err && !serr_ok) check_eq("spurious_sync_err", 32'(sync_err), 32'd0);
    end

    task automatic send(input logic e, input logic d, input logic s);
        en   = e;
        din  = d;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int slot, input logic [7:0] w, input bit with_sync,
                             input bit gap, input bit expect_out, input bit serr_exp);
        for (int i = 0; i < 8; i++) begin
            if (gap) send(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 0) serr_ok = serr_exp;
            if (i == 7 && expect_out) exp_q.push_back('{slot: slot, word: w, cyc: cyc + 1});
            send(1'b1, w[7-i], with_sync && (i == 0));
            if (i == 0) check_eq("sync_err_first_bit", 32'(sync_err), 32'(serr_exp));
            if (i == 1) serr_ok = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input bit gap);
        send_word(0, f[31:24], 1'b1, gap, 1'b1, 1'b0);
        send_word(1, f[23:16], 1'b0, gap, 1'b1, 1'b0);
        send_word(2, f[15:8],  1'b0, gap, 1'b1, 1'b0);
        send_word(3, f[7:0],   1'b0, gap, 1'b1, 1'b0);
    endtask

    task automatic check_chans(input string tag, input logic [31:0] f);
        check_eq({tag, "_all"}, {ch0, ch1, ch2, ch3}, f);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        din  = 1'b0;
        sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_chans("reset", 32'h0);
        check_eq("reset_pulses", {26'b0, ch_valid, frame_done, sync_err}, 32'd0);
        check_eq("reset_locked", 32'(locked), 32'd0);
        rst = 1'b0;

        // Nominal frame, then the same-style frame with en gaps.
        send_frame(32'hA53C_FF01, 1'b0);
        check_chans("nominal", 32'hA53C_FF01);
        check_eq("nominal_locked", 32'(locked), 32'd1);
        send_frame(32'h5AC3_0080, 1'b1);
        check_chans("gapped", 32'h5AC3_0080);

        // Missing sync at frame start drops to hunt; the rest of the frame is ignored.
        send_word(0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("missing_sync_locked", 32'(locked), 32'd0);
        send_word(1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(3, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        check_chans("missing_sync_hold", 32'h5AC3_0080);

        // Hunt: unsynced bits have no effect.
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            check_eq("hunt_locked", 32'(locked), 32'd0);
        end
        check_chans("hunt_hold", 32'h5AC3_0080);
        send_frame(32'h1234_5678, 1'b0);
        check_chans("hunt_frame", 32'h1234_5678);

        // Misplaced sync at slot 1 bit 3 restarts the frame at that bit.
        send_word(0, 8'h9A, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) send(1'b1, 1'b1, 1'b0);
        send_word(0, 8'hDE, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("misplaced_locked", 32'(locked), 32'd1);
        check_eq("misplaced_ch1_hold", 32'(ch1), 32'h34);
        send_word(1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(2, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(3, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
        check_chans("misplaced_frame", 32'hDEAD_BEEF);

        // Reset after 12 bits, with en/sync/din active to check reset priority.
        send_word(0, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) send(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        send(1'b1, 1'b1, 1'b1);
        check_chans("midreset", 32'h0);
        check_eq("midreset_locked", 32'(locked), 32'd0);
        check_eq("midreset_pulses", {26'b0, ch_valid, frame_done, sync_err}, 32'd0);
        rst = 1'b0;
        send_frame(32'h0102_0304, 1'b0);
        check_chans("after_reset", 32'h0102_0304);

        repeat (3) send(1'b0, 1'b0, 1'b0);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, 8, bits per channel slot; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 en  input  1  bit-valid qualifier; din and sync are sampled only when en=1.
REQ-005 din  input  1  serial data; slot order ch0..ch3; each slot is MSB first.
REQ-006 sync  input  1  frame marker; asserted with the first bit (ch0 MSB) of every frame.
REQ-007 ch0, ch1, ch2, ch3  output  W each  last completed word per channel; registered.
REQ-008 ch_valid  output  4  one-cycle pulse; bit k marks a new chk word.
REQ-009 frame_done  output  1  one-cycle pulse when the ch3 word of a frame completes.
REQ-010 locked  output  1  high while the state is LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a misplaced or missing sync.

Function
REQ-012 The block SHALL use two states: HUNT and LOCKED.
REQ-013 The block SHALL keep a bit counter (0..W-1), a slot counter (0..3) and a W-bit shift register.
REQ-014 Cycles with en=0 SHALL leave all state unchanged and deassert all pulse outputs.
REQ-015 In HUNT with en=1 and sync=0, the bit SHALL be discarded.
REQ-016 In HUNT with en=1 and sync=1, the block SHALL enter LOCKED, take din as slot 0 bit 0, and set the bit counter to 1 and the slot counter to 0.
REQ-017 In LOCKED with en=1, din SHALL shift into the LSB of the shift register, and the bit counter SHALL increment.
REQ-018 Wrap-around: on the bit with bit counter = W-1, the bit counter SHALL go to 0 and the slot counter SHALL increment modulo 4.
REQ-019 On that completing bit, the word {shift[W-2:0], din} SHALL load into ch<slot> and ch_valid[slot] SHALL pulse; both are visible on the next cycle (latency 1 clk after the last bit is accepted).
REQ-020 The completion of slot 3 SHALL also pulse frame_done in the same cycle as ch_valid[3].
REQ-021 Outputs chk SHALL hold their value until the next completion of slot k.
REQ-022 Misplaced sync (LOCKED, en=1, sync=1, position not slot 0 bit 0): sync_err SHALL pulse, the partial word SHALL be discarded, and the bit SHALL be taken as slot 0 bit 0; the block stays LOCKED.
REQ-023 Missing sync (LOCKED, en=1, sync=0 at slot 0 bit 0): sync_err SHALL pulse, the bit SHALL be discarded, and the block SHALL return to HUNT with counters cleared.
REQ-024 Sync at the expected position SHALL be accepted silently.
REQ-025 At most one ch_valid bit SHALL be high in any cycle.
REQ-026 The block SHALL never output a partially assembled word.

Reset
REQ-027 While rst=1 at a clock edge: state becomes HUNT, counters and shift register clear, ch0..ch3=0, ch_valid=0, frame_done=0, sync_err=0, locked=0.
REQ-028 rst SHALL take priority over en, sync and din in the same cycle.
REQ-029 A reset in mid-frame SHALL discard the partial frame; no ch_valid pulse is produced for it.

Verification
REQ-030 Nominal: W=8, en=1, sync on bit 0, 32 bits encoding 0xA5,0x3C,0xFF,0x01 -> ch_valid pulses 0001,0010,0100,1000 at bits 8,16,24,32 (+1 clk); frame_done coincides with the ch3 pulse; final ch0..3 = A5,3C,FF,01.
REQ-031 Gapped: same frame with en=0 on every other cycle -> identical words and pulses; pulse spacing stretched; no pulse during en=0 cycles.
REQ-032 Hunt: 5 random bits with sync=0, then the nominal frame -> locked is 0 until sync, and the first five bits have no effect.
REQ-033 Misplaced sync: sync asserted at slot 1 bit 3 -> sync_err pulses 1 clk; ch1 is not updated; the next 32 bits decode as a full frame starting at that bit.
REQ-034 Missing sync: second frame sent without sync -> sync_err pulses, locked=0 next cycle, and ch0..3 keep their first-frame values.
REQ-035 Reset mid-frame: rst=1 after 12 bits -> all outputs 0, locked=0; a following frame with sync decodes correctly.
